mem_access_stage: RTL and testbench

Memory-access pipeline stage of the MIPS R2000 core, between execute and writeback. Performs byte/halfword/word loads and stores on the byte-addressed data RAM, in big-endian order. Registers the instruction's control and result fields into the MEM/WB pipeline register that drives the writeback mux and the register-file write port. Single-issue: at most one memory operation per cycle.

---
 rtl/mem_access_stage_pkg.sv | 46 ++++
 rtl/mem_access_stage_if.sv | 43 ++++
 rtl/mem_access_stage_load_align.sv | 39 +++
 rtl/mem_access_stage.sv | 127 ++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants, access-size encoding and MEM/WB register layout for the
// memory-access stage.
package mem_access_stage_pkg;

  localparam int WIDTH          = 32;
  localparam int BYTE           = 8;
  localparam int RAM_SIZE       = 256;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int RAM_ADDR_WIDTH = $clog2(RAM_SIZE);

  // 2'b11 is reserved and handled as a word access everywhere.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic                      valid;
    logic                      load;
    logic                      alu_mode;
    logic                      rd;
    logic                      err;
    logic [WIDTH-1:0]          pc;
    logic [WIDTH-1:0]          alu_result;
    logic [WIDTH-1:0]          read_data;
    logic [REG_ADDR_WIDTH-1:0] rd_address;
  } memwb_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      default:  is_misaligned = |off;
    endcase
  endfunction

  function automatic logic [1:0] align_mask(input mem_size_t size);
    case (size)
      MEM_BYTE: align_mask = 2'b00;
      MEM_HALF: align_mask = 2'b01;
      default:  align_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX-side inputs and MEM/WB outputs of the memory-access stage.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic                             stall;
  logic                             valid_ex;
  logic [WIDTH-1:0]                 pc_ex;
  logic                             load_ex;
  logic                             store_ex;
  mem_size_t                        size_ex;
  logic                             unsigned_ex;
  logic                             alu_mode_ex;
  logic [WIDTH-1:0]                 alu_result_ex;
  logic [WIDTH-1:0]                 store_data_ex;
  logic                             rd_ex;
  logic [REG_ADDR_WIDTH-1:0]        rd_address_ex;

  logic [RAM_SIZE-1:0][BYTE-1:0]    ram;
  logic                             valid_mem;
  logic                             load_mem;
  logic                             alu_mode_mem;
  logic                             rd_mem;
  logic [WIDTH-1:0]                 pc_mem;
  logic [WIDTH-1:0]                 alu_result_mem;
  logic [WIDTH-1:0]                 read_data_mem;
  logic [REG_ADDR_WIDTH-1:0]        rd_address_mem;
  logic                             addr_error_mem;

  modport master (
    output stall, valid_ex, pc_ex, load_ex, store_ex, size_ex, unsigned_ex,
           alu_mode_ex, alu_result_ex, store_data_ex, rd_ex, rd_address_ex,
    input  ram, valid_mem, load_mem, alu_mode_mem, rd_mem, pc_mem,
           alu_result_mem, read_data_mem, rd_address_mem, addr_error_mem
  );

  modport slave (
    input  stall, valid_ex, pc_ex, load_ex, store_ex, size_ex, unsigned_ex,
           alu_mode_ex, alu_result_ex, store_data_ex, rd_ex, rd_address_ex,
    output ram, valid_mem, load_mem, alu_mode_mem, rd_mem, pc_mem,
           alu_result_mem, read_data_mem, rd_address_mem, addr_error_mem
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension. bytes_i[k] is the byte at
// word address base+k.
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [3:0][BYTE-1:0] bytes_i,
  input  logic [1:0]           offset_i,
  input  mem_size_t            size_i,
  input  logic                 unsigned_i,
  output logic [WIDTH-1:0]     data_o
);

  logic [BYTE-1:0]   byte_sel;
  logic [2*BYTE-1:0] half_sel;

  // Pick the addressed lane(s), then extend to the full register width.
  always_comb begin
    byte_sel = bytes_i[offset_i];
    if (BIG_ENDIAN) begin
      half_sel = {bytes_i[{offset_i[1], 1'b0}], bytes_i[{offset_i[1], 1'b1}]};
    end else begin
      half_sel = {bytes_i[{offset_i[1], 1'b1}], bytes_i[{offset_i[1], 1'b0}]};
    end
    case (size_i)
      MEM_BYTE: data_o = {{(WIDTH-BYTE){~unsigned_i & byte_sel[BYTE-1]}}, byte_sel};
      MEM_HALF: data_o = {{(WIDTH-2*BYTE){~unsigned_i & half_sel[2*BYTE-1]}}, half_sel};
      default: begin
        if (BIG_ENDIAN) begin
          data_o = {bytes_i[0], bytes_i[1], bytes_i[2], bytes_i[3]};
        end else begin
          data_o = {bytes_i[3], bytes_i[2], bytes_i[1], bytes_i[0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: data RAM plus MEM/WB pipeline register.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses instead of masking them.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.slave bus
);

  logic [RAM_SIZE-1:0][BYTE-1:0] ram_q, ram_d;
  memwb_t                        memwb_q, memwb_d;

  logic [RAM_ADDR_WIDTH-1:0] raw_addr;
  logic [RAM_ADDR_WIDTH-1:0] addr;
  logic                      misaligned;
  logic [3:0][BYTE-1:0]      fetched;
  logic [3:0]                lane_en;
  logic [3:0][1:0]           lane_sel;
  logic [3:0][BYTE-1:0]      lane_byte;
  logic                      ram_we;
  logic [WIDTH-1:0]          load_data;

  assign raw_addr = bus.alu_result_ex[RAM_ADDR_WIDTH-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = bus.valid_ex & (bus.load_ex | bus.store_ex)
                    & is_misaligned(bus.size_ex, raw_addr[1:0]);
  assign addr       = raw_addr;
`else
  assign misaligned = 1'b0;
  assign addr       = {raw_addr[RAM_ADDR_WIDTH-1:2], raw_addr[1:0] & ~align_mask(bus.size_ex)};
`endif

  assign ram_we = bus.valid_ex & bus.store_ex & ~bus.stall & ~misaligned;

  // Word fetch and per-lane store data; accesses never cross a word.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fetched[k] = ram_q[{addr[RAM_ADDR_WIDTH-1:2], k[1:0]}];
      case (bus.size_ex)
        MEM_BYTE: begin
          lane_en[k]  = (k[1:0] == addr[1:0]);
          lane_sel[k] = 2'b00;
        end
        MEM_HALF: begin
          lane_en[k]  = (k[1] == addr[1]);
          lane_sel[k] = {1'b0, BIG_ENDIAN ? ~k[0] : k[0]};
        end
        default: begin
          lane_en[k]  = 1'b1;
          lane_sel[k] = BIG_ENDIAN ? ~k[1:0] : k[1:0];
        end
      endcase
      lane_byte[k] = bus.store_data_ex[{lane_sel[k], 3'b000} +: BYTE];
    end
  end

  // RAM next state: only enabled lanes of a committed store change.
  always_comb begin
    ram_d = ram_q;
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          ram_d[{addr[RAM_ADDR_WIDTH-1:2], k[1:0]}] = lane_byte[k];
        end else begin
          ram_d[{addr[RAM_ADDR_WIDTH-1:2], k[1:0]}] = ram_q[{addr[RAM_ADDR_WIDTH-1:2], k[1:0]}];
        end
      end
    end else begin
      ram_d = ram_q;
    end
  end

  mem_access_stage_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
    .bytes_i    (fetched),
    .offset_i   (addr[1:0]),
    .size_i     (bus.size_ex),
    .unsigned_i (bus.unsigned_ex),
    .data_o     (load_data)
  );

  // MEM/WB next state: hold on stall, clear on bubble, else capture EX fields.
  always_comb begin
    memwb_d = memwb_q;
    if (bus.stall) begin
      memwb_d = memwb_q;
    end else if (!bus.valid_ex) begin
      memwb_d = '0;
    end else begin
      memwb_d.valid      = 1'b1;
      memwb_d.load       = bus.load_ex & ~misaligned;
      memwb_d.alu_mode   = bus.alu_mode_ex;
      memwb_d.rd         = bus.rd_ex & ~misaligned;
      memwb_d.err        = misaligned;
      memwb_d.pc         = bus.pc_ex;
      memwb_d.alu_result = bus.alu_result_ex;
      memwb_d.read_data  = (bus.load_ex & ~misaligned) ? load_data : {WIDTH{1'b0}};
      memwb_d.rd_address = bus.rd_address_ex;
    end
  end

  // State registers; reset clears the RAM and drops any in-flight store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_q   <= '0;
      memwb_q <= '0;
    end else begin
      ram_q   <= ram_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ram            = ram_q;
  assign bus.valid_mem      = memwb_q.valid;
  assign bus.load_mem       = memwb_q.load;
  assign bus.alu_mode_mem   = memwb_q.alu_mode;
  assign bus.rd_mem         = memwb_q.rd;
  assign bus.pc_mem         = memwb_q.pc;
  assign bus.alu_result_mem = memwb_q.alu_result;
  assign bus.read_data_mem  = memwb_q.read_data;
  assign bus.rd_address_mem = memwb_q.rd_address;
  assign bus.addr_error_mem = memwb_q.err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, stall/bubble/reset
// sequences and random traffic against a byte-array reference model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus();

  mem_access_stage #(.BIG_ENDIAN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  model_mem [RAM_SIZE];
  logic        e_valid, e_load, e_alu, e_rd, e_err;
  logic [31:0] e_pc, e_alu_res, e_rdata;
  logic [4:0]  e_rda;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic am, input logic [31:0] a,
                       input logic [31:0] d, input logic rd, input logic [4:0] rda,
                       input logic stl);
    bus.valid_ex      = v;
    bus.load_ex       = ld;
    bus.store_ex      = st;
    bus.size_ex       = mem_size_t'(sz);
    bus.unsigned_ex   = uns;
    bus.alu_mode_ex   = am;
    bus.alu_result_ex = a;
    bus.store_data_ex = d;
    bus.rd_ex         = rd;
    bus.rd_address_ex = rda;
    bus.pc_ex         = $urandom;
    bus.stall         = stl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < RAM_SIZE; i++) model_mem[i] = 8'h00;
    {e_valid, e_load, e_alu, e_rd, e_err} = 5'b0;
    e_pc = 32'h0; e_alu_res = 32'h0; e_rdata = 32'h0; e_rda = 5'h0;
  endtask

  // Reference: big-endian byte array, evaluated from the EX inputs before the edge.
  task automatic model_edge();
    int unsigned a, n;
    bit          mis, err;
    longint unsigned v, lim;
    logic [31:0] sh;
    if (bus.stall) return;
    if (!bus.valid_ex) begin
      {e_valid, e_load, e_alu, e_rd, e_err} = 5'b0;
      e_pc = 32'h0; e_alu_res = 32'h0; e_rdata = 32'h0; e_rda = 5'h0;
      return;
    end
    a   = bus.alu_result_ex % RAM_SIZE;
    n   = (bus.size_ex == MEM_BYTE) ? 1 : (bus.size_ex == MEM_HALF) ? 2 : 4;
    mis = (a % n) != 0;
    err = CHECK && mis && (bus.load_ex || bus.store_ex);
    if (!CHECK) a = a - (a % n);
    e_rdata = 32'h0;
    if (bus.load_ex && !err) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | model_mem[a + i];
      lim = 64'd1 << (8 * n);
      if (n < 4 && !bus.unsigned_ex && v >= lim / 2) v = v + (64'd1 << 32) - lim;
      e_rdata = v[31:0];
    end
    if (bus.store_ex && !err) begin
      for (int i = 0; i < n; i++) begin
        sh = bus.store_data_ex >> (8 * (n - 1 - i));
        model_mem[a + i] = sh[7:0];
      end
    end
    e_valid   = 1'b1;
    e_load    = bus.load_ex && !err;
    e_rd      = bus.rd_ex && !err;
    e_alu     = bus.alu_mode_ex;
    e_err     = err;
    e_pc      = bus.pc_ex;
    e_alu_res = bus.alu_result_ex;
    e_rda     = bus.rd_address_ex;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_mem"},      bus.valid_mem,      e_valid);
    chk({tag, ".load_mem"},       bus.load_mem,       e_load);
    chk({tag, ".alu_mode_mem"},   bus.alu_mode_mem,   e_alu);
    chk({tag, ".rd_mem"},         bus.rd_mem,         e_rd);
    chk({tag, ".pc_mem"},         bus.pc_mem,         e_pc);
    chk({tag, ".alu_result_mem"}, bus.alu_result_mem, e_alu_res);
    chk({tag, ".rd_address_mem"}, bus.rd_address_mem, e_rda);
    chk({tag, ".addr_error_mem"}, bus.addr_error_mem, e_err);
    if (e_load) chk({tag, ".read_data_mem"}, bus.read_data_mem, e_rdata);
  endtask

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < RAM_SIZE; i++) if (bus.ram[i] !== model_mem[i]) bad++;
    chk({tag, ".ram_bytes_differing"}, bad, 0);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_clear();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check_ram("reset");
    rst = 1'b1;

    //          ld    st    sz     uns   addr             data          exp_rdata     exp_err
    vt[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10,          32'h12345678, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10,          32'h0,        32'h12345678, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h21,          32'hDEADBE80, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h21,          32'h0,        32'hFFFFFF80, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h21,          32'h0,        32'h00000080, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h22,          32'h1234BEEF, 32'h0,        1'b0};
    vt[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h22,          32'h0,        32'hFFFFBEEF, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h22,          32'h0,        32'h0000BEEF, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20,          32'h0,        32'h0080BEEF, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, RAM_SIZE + 4,    32'hCAFEF00D, 32'h0,        1'b0};
    vt[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h4,           32'h0,        32'hCAFEF00D, 1'b0};
    vt[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h11,          32'h0,        32'h12345678, CHECK};
    vt[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h10,          32'h0,        32'h12345678, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vt[i].ld, vt[i].st, vt[i].sz, vt[i].uns, 1'b0, vt[i].addr, vt[i].data,
            vt[i].ld, 5'(i + 1), 1'b0);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.err", i), bus.addr_error_mem, vt[i].exp_err);
      chk($sformatf("vec%0d.rd", i), bus.rd_mem, vt[i].ld & ~vt[i].exp_err);
      if (vt[i].ld && !vt[i].exp_err)
        chk($sformatf("vec%0d.rdata", i), bus.read_data_mem, vt[i].exp_rdata);
    end
    chk("sw_byte10", bus.ram[16], 32'h12);
    chk("sw_byte11", bus.ram[17], 32'h34);
    chk("sw_byte12", bus.ram[18], 32'h56);
    chk("sw_byte13", bus.ram[19], 32'h78);
    chk("sh_byte20", bus.ram[32], 32'h00);
    chk("sh_byte21", bus.ram[33], 32'h80);
    chk("wrap_byte4", bus.ram[4], 32'hCA);
    chk("wrap_byte7", bus.ram[7], 32'h0D);
    check_ram("table");

    // Stalled store held for three cycles must leave RAM and outputs alone.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h30, 32'h11223344, 1'b0, 5'd9, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step($sformatf("stall%0d", c));
      chk($sformatf("stall%0d.ram30", c), bus.ram[48], 32'h00);
    end
    check_ram("stall");

    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 5'd7, 1'b0);
    step("bubble");
    chk("bubble.rd_mem", bus.rd_mem, 1'b0);

    for (int it = 0; it < 400; it++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 63) + (($urandom_range(0, 1) == 1) ? RAM_SIZE * $urandom_range(1, 3) : 0);
      drive($urandom_range(0, 9) != 0, kind == 1, kind == 2, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
      step("rand");
      if (it % 50 == 49) check_ram("rand");
    end
    check_ram("rand_end");

    // Reset asserted during a store: everything clears and the store never lands.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h40, 32'hAABBCCDD, 1'b0, 5'd3, 1'b1);
    #2 rst = 1'b0;
    #2;
    model_clear();
    check_outputs("rst_mid");
    check_ram("rst_mid");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
    rst = 1'b1;
    step("rst_release");
    check_ram("rst_release");
    chk("rst_release.byte40", bus.ram[64], 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
